hex_loader: RTL and testbench
=============================

# hex_loader

Streaming loader for the single-cycle CPU's instruction memory: consumes an ASCII hex text stream, one character per handshake, in the same format the instruction-dump path emits (one 32-bit word per line, eight hex digits, LF-terminated). Each complete line is packed into a 32-bit word and written to instruction memory at consecutive word addresses from a base. The block sits between the bench/host character source and the IM write port, ahead of CPU release from reset.

## Interface
- DEPTH, 4096: IM capacity in words, ≤ 4096.
- BASE, 32'h0000_3000: byte address of the first word written.

- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; 0 clears all state immediately.
- in_valid  in  1  in_data holds a character.
- in_data  in  8  ASCII character.
- in_ready  out  1  block can accept a character this cycle.
- wr_en  out  1  IM write strobe, one cycle per word.
- wr_addr  out  32  IM byte address, BASE + 4*word_cnt, modulo 2^32.
- wr_data  out  32  packed word; first digit received is bits [31:28].
- word_cnt  out  13  words written since reset.
- err  out  1  sticky format-error flag.
- full  out  1  sticky; word_cnt reached DEPTH.
- done  out  1  end of stream (EOT) seen.

## Operation
- Character accepted on a rising clk edge with in_valid && in_ready. No other input has any effect.
- Digit classes:
  - '0'-'9', 'a'-'f', 'A'-'F' are hex digits.
  - LF (0x0A) ends a line.
  - CR (0x0D) and space (0x20) are ignored.
  - EOT (0x04) ends the stream.
  - Every other character is illegal.
- Registers: shift word (32), digit_cnt (0..8), word_cnt, err, full, state.
- States: COLLECT (reset state), SKIP, WRITE, DONE.
- COLLECT:
  - Hex digit with digit_cnt < 8: word <= {word[27:0], nibble}, digit_cnt+1.
  - Hex digit with digit_cnt == 8: err <= 1, go to SKIP.
  - LF with digit_cnt == 8: go to WRITE.
  - LF with digit_cnt == 0: blank line, stay.
  - LF with digit_cnt 1..7: err <= 1, clear digit_cnt, stay.
  - Illegal character: err <= 1, go to SKIP.
  - EOT: if digit_cnt ≠ 0, err <= 1 and the partial word is discarded; go to DONE.
- SKIP:
  - Every character is discarded.
  - LF: clear digit_cnt, go to COLLECT.
  - EOT: go to DONE.
- WRITE (exactly one cycle):
  - in_ready = 0.
  - If full = 0: wr_en = 1 with wr_data = word and wr_addr = BASE + 4*word_cnt. word_cnt+1 on the closing edge; full <= 1 if the new count equals DEPTH.
  - If full = 1: wr_en = 0, err <= 1, word dropped.
  - Closing edge clears digit_cnt and word; go to COLLECT.
- DONE: in_ready = 0, done = 1. Held until reset.
- wr_en is asserted only in WRITE with full = 0.
- wr_data is driven from the shift register in all states.
- word_cnt saturates at DEPTH. wr_addr is never re-used.

## Timing
- Reset values:
  - state COLLECT, in_ready 1.
  - wr_en 0, wr_data 0, wr_addr BASE.
  - word_cnt 0, err 0, full 0, done 0.
  - digit_cnt 0.
- in_ready is combinational from state: 1 in COLLECT and SKIP, 0 in WRITE and DONE.
- LF accepted at edge N: wr_en high for the whole cycle N..N+1, and IM captures on edge N+1. word_cnt and wr_addr advance at edge N+1.
- Minimum line cost is 10 cycles (9 characters plus 1 write cycle). Back-to-back in_valid is stalled one cycle after each complete LF.
- Reset asserted mid-WRITE: wr_en drops asynchronously and the word is not counted.
- Sticky flags err, full and done clear only on reset.

## Test plan
- Stream "24010005\n3c01abcd\n" then EOT:
  - wr_en pulses twice: (32'h3000, 32'h24010005), then (32'h3004, 32'h3c01abcd).
  - word_cnt = 2, done = 1, err = 0, in_ready = 0.
- Stream "DEADBEEF\r\n\n \n":
  - One write of 32'hdeadbeef; err = 0.
  - in_ready low for exactly the one cycle after LF.
- Stream "1234\n", "12345678g\n", "123456789\n", then "00000001\n":
  - err = 1, no writes for the first three lines.
  - Fourth line writes 32'h00000001 at 32'h3000.
- DEPTH = 2, four valid lines:
  - Two writes; full = 1 after the second.
  - Lines 3 and 4 produce no wr_en; err = 1; word_cnt stays 2.
- Pull reset low in the WRITE cycle of line 2, release, then send "0000000a\n":
  - wr_en falls at once, all outputs return to reset values.
  - New word written at 32'h3000.
- Stream "abc" then EOT:
  - done = 1, err = 1, no write.
  - Further in_valid characters are ignored.

Source files
------------

// File: rtl/hex_loader_if.sv
// hex_loader_if: character stream in, instruction-memory write port out
interface hex_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  modport slave (input in_valid, in_data, output in_ready, wr_en, wr_addr, wr_data);
  modport master (output in_valid, in_data, input in_ready, wr_en, wr_addr, wr_data);
endinterface

// File: rtl/hex_loader.sv
// hex_loader: packs LF-terminated 8-digit ASCII hex lines into IM words at consecutive addresses
module hex_loader #(
  parameter int          DEPTH = 4096,
  parameter logic [31:0] BASE  = 32'h0000_3000
) (
  input  logic         clk,
  input  logic         reset,
  hex_loader_if.slave  bus,
  output logic [12:0]  word_cnt,
  output logic         err,
  output logic         full,
  output logic         done
);
  typedef enum logic [1:0] {COLLECT, SKIP, WRITE, DONE} state_t;
  localparam logic [7:0]  LF = 8'h0a, CR = 8'h0d, SP = 8'h20, EOT = 8'h04;
  localparam logic [12:0] DEPTH_C = 13'(DEPTH);
  state_t      state, state_n;
  logic [31:0] word, word_n;
  logic [3:0]  dcnt, dcnt_n;
  logic [12:0] wcnt_n;
  logic        err_n, full_n;
  logic [7:0]  c;
  logic        is_dec, is_alpha, is_hex, acc;
  logic [3:0]  nib;
  assign c        = bus.in_data;
  assign is_dec   = c >= 8'h30 && c <= 8'h39;
  assign is_alpha = (c >= 8'h61 && c <= 8'h66) || (c >= 8'h41 && c <= 8'h46);
  assign is_hex   = is_dec || is_alpha;
  assign nib      = is_dec ? c[3:0] : c[3:0] + 4'd9;
  assign bus.in_ready = state == COLLECT || state == SKIP;
  assign acc      = bus.in_valid && bus.in_ready;
  assign bus.wr_en   = state == WRITE && !full;
  assign bus.wr_data = word;
  assign bus.wr_addr = BASE + {17'd0, word_cnt, 2'b00};
  assign done     = state == DONE;
  always_comb begin
    state_n = state;
    word_n  = word;
    dcnt_n  = dcnt;
    wcnt_n  = word_cnt;
    err_n   = err;
    full_n  = full;
    case (state)
      COLLECT: if (acc) begin
        if (is_hex) begin
          if (dcnt == 4'd8) begin
            err_n   = 1'b1;
            state_n = SKIP;
          end else begin
            word_n = {word[27:0], nib};
            dcnt_n = dcnt + 4'd1;
          end
        end else if (c == LF) begin
          if (dcnt == 4'd8) state_n = WRITE;
          else if (dcnt != 4'd0) begin
            err_n  = 1'b1;
            dcnt_n = 4'd0;
          end
        end else if (c == EOT) begin
          err_n   = err || dcnt != 4'd0;
          state_n = DONE;
        end else if (c != CR && c != SP) begin
          err_n   = 1'b1;
          state_n = SKIP;
        end
      end
      SKIP: if (acc) begin
        if (c == LF) begin
          dcnt_n  = 4'd0;
          state_n = COLLECT;
        end else if (c == EOT) state_n = DONE;
      end
      WRITE: begin
        // once full, further complete lines are flagged and dropped
        if (full) err_n = 1'b1;
        else begin
          wcnt_n = word_cnt + 13'd1;
          full_n = word_cnt + 13'd1 == DEPTH_C;
        end
        dcnt_n  = 4'd0;
        word_n  = 32'd0;
        state_n = COLLECT;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= COLLECT;
      word     <= 32'd0;
      dcnt     <= 4'd0;
      word_cnt <= 13'd0;
      err      <= 1'b0;
      full     <= 1'b0;
    end else begin
      state    <= state_n;
      word     <= word_n;
      dcnt     <= dcnt_n;
      word_cnt <= wcnt_n;
      err      <= err_n;
      full     <= full_n;
    end
  end
endmodule

// File: tb/tb_hex_loader.sv
// tb_hex_loader: table, hand-written and random streams checked against a line-level model
module tb_hex_loader;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [12:0] wc_a, wc_b;
  logic err_a, err_b, full_a, full_b, done_a, done_b;
  int total = 0;
  int bad = 0;
  int lowc = 0;
  logic [63:0] obs_a[$], obs_b[$], exp_q[$];
  logic exp_err, exp_done;
  int exp_cnt;
  hex_loader_if ia();
  hex_loader_if ib();
  assign ib.in_valid = ia.in_valid;
  assign ib.in_data  = ia.in_data;
  hex_loader u_a (.clk(clk), .reset(reset), .bus(ia), .word_cnt(wc_a), .err(err_a), .full(full_a), .done(done_a));
  hex_loader #(.DEPTH(2)) u_b (.clk(clk), .reset(reset), .bus(ib), .word_cnt(wc_b), .err(err_b), .full(full_b), .done(done_b));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (ia.wr_en) obs_a.push_back({ia.wr_addr, ia.wr_data});
    if (ib.wr_en) obs_b.push_back({ib.wr_addr, ib.wr_data});
    if (reset && !ia.in_ready) lowc++;
  end
  typedef struct {
    string s;
    int    nwa;
    int    nwb;
    bit    ea;
    bit    eb;
    bit    dn;
  } vec_t;
  vec_t tbl[5];
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask
  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    ia.in_valid = 1'b0;
    ia.in_data = 8'h00;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    obs_a.delete();
    obs_b.delete();
    lowc = 0;
  endtask
  task automatic put(input byte ch);
    int n = 0;
    @(negedge clk);
    ia.in_valid = 1'b1;
    ia.in_data = ch;
    while (!ia.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!ia.in_ready) begin
      total++;
      bad++;
      $display("FAIL put_timeout in_ready=%b want=1 char=%0h", ia.in_ready, ch);
    end else begin
      @(posedge clk);
      #1;
    end
    ia.in_valid = 1'b0;
  endtask
  function automatic int nibv(input byte c);
    if (c >= "0" && c <= "9") return int'(c) - 48;
    if (c >= "a" && c <= "f") return int'(c) - 87;
    if (c >= "A" && c <= "F") return int'(c) - 55;
    return -1;
  endfunction
  // line-at-a-time reference: a line writes only if it holds exactly 8 digits and nothing illegal
  task automatic model(input string s, input int depth);
    int nd = 0;
    bit lbad = 0;
    logic [31:0] v = 0;
    exp_q.delete();
    exp_err = 0;
    exp_done = 0;
    exp_cnt = 0;
    for (int i = 0; i < s.len() && !exp_done; i++) begin
      byte c = s[i];
      int  h = nibv(c);
      if (c == 8'h0a) begin
        if (!lbad && nd == 8) begin
          if (exp_cnt < depth) begin
            exp_q.push_back({32'h3000 + 32'(exp_cnt) * 4, v});
            exp_cnt++;
          end else exp_err = 1;
        end else if (!lbad && nd != 0) exp_err = 1;
        nd = 0;
        lbad = 0;
        v = 0;
      end else if (c == 8'h04) begin
        if (lbad || nd != 0) exp_err = 1;
        exp_done = 1;
      end else if (h >= 0) begin
        nd++;
        v = (v << 4) + 32'(h);
        if (nd > 8) begin
          lbad = 1;
          exp_err = 1;
        end
      end else if (c != 8'h0d && c != 8'h20) begin
        lbad = 1;
        exp_err = 1;
      end
    end
  endtask
  task automatic run_stream(input string s);
    apply_reset();
    for (int i = 0; i < s.len(); i++) put(s[i]);
    repeat (3) @(negedge clk);
    model(s, 4096);
    check("a_nwrites", 64'(obs_a.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_a.size(); i++) check("a_write", obs_a[i], exp_q[i]);
    check("a_err", 64'(err_a), 64'(exp_err));
    check("a_done", 64'(done_a), 64'(exp_done));
    check("a_word_cnt", 64'(wc_a), 64'(exp_cnt));
    check("a_full", 64'(full_a), 64'(exp_cnt == 4096));
    model(s, 2);
    check("b_nwrites", 64'(obs_b.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_b.size(); i++) check("b_write", obs_b[i], exp_q[i]);
    check("b_err", 64'(err_b), 64'(exp_err));
    check("b_done", 64'(done_b), 64'(exp_done));
    check("b_word_cnt", 64'(wc_b), 64'(exp_cnt));
    check("b_full", 64'(full_b), 64'(exp_cnt == 2));
  endtask
  function automatic string gen();
    string s = "";
    string hx = "0123456789abcdefABCDEF";
    string il = "gGxz#:/@~\t";
    string ws = " \015";
    int n = $urandom_range(1, 6);
    for (int l = 0; l < n; l++) begin
      int t = $urandom_range(0, 9);
      int nd = t < 6 ? 8 : t == 6 ? $urandom_range(1, 7) : t == 7 ? $urandom_range(9, 11) : t == 9 ? 0 : $urandom_range(0, 8);
      int ip = t == 8 ? $urandom_range(0, nd) : -1;
      for (int k = 0; k <= nd; k++) begin
        if (k == ip) s = $sformatf("%s%c", s, il[$urandom_range(0, il.len() - 1)]);
        if (k < nd) s = $sformatf("%s%c", s, hx[$urandom_range(0, hx.len() - 1)]);
        if ($urandom_range(0, 7) == 0) s = $sformatf("%s%c", s, ws[$urandom_range(0, 1)]);
      end
      s = {s, "\n"};
    end
    if ($urandom_range(0, 1) == 1) begin
      int f = $urandom_range(0, 3);
      for (int k = 0; k < f; k++) s = $sformatf("%s%c", s, hx[$urandom_range(0, hx.len() - 1)]);
      s = {s, "\004"};
    end
    return s;
  endfunction
  initial begin
    #3000000;
    $display("FAIL watchdog elapsed=%0t limit=3000000", $time);
    $fatal(1, "watchdog");
  end
  initial begin
    tbl[0] = '{"24010005\n3c01abcd\n\004", 2, 2, 0, 0, 1};
    tbl[1] = '{"DEADBEEF\015\n\n \n", 1, 1, 0, 0, 0};
    tbl[2] = '{"1234\n12345678g\n123456789\n00000001\n", 1, 1, 1, 1, 0};
    tbl[3] = '{"abc\004", 0, 0, 1, 1, 1};
    tbl[4] = '{"11111111\n22222222\n33333333\n44444444\n", 4, 2, 0, 1, 0};
    ia.in_valid = 1'b0;
    ia.in_data = 8'h00;
    apply_reset();
    check("rst_in_ready", 64'(ia.in_ready), 64'd1);
    check("rst_wr_en", 64'(ia.wr_en), 64'd0);
    check("rst_wr_data", 64'(ia.wr_data), 64'd0);
    check("rst_wr_addr", 64'(ia.wr_addr), 64'h3000);
    check("rst_flags", {wc_a, err_a, full_a, done_a}, 64'd0);
    for (int i = 0; i < 5; i++) begin
      run_stream(tbl[i].s);
      check($sformatf("tbl%0d_nwa", i), 64'(obs_a.size()), 64'(tbl[i].nwa));
      check($sformatf("tbl%0d_nwb", i), 64'(obs_b.size()), 64'(tbl[i].nwb));
      check($sformatf("tbl%0d_erra", i), 64'(err_a), 64'(tbl[i].ea));
      check($sformatf("tbl%0d_errb", i), 64'(err_b), 64'(tbl[i].eb));
      check($sformatf("tbl%0d_done", i), 64'(done_a), 64'(tbl[i].dn));
    end
    run_stream("24010005\n3c01abcd\n\004");
    check("plan1_w0", obs_a[0], {32'h3000, 32'h24010005});
    check("plan1_w1", obs_a[1], {32'h3004, 32'h3c01abcd});
    check("plan1_ready", 64'(ia.in_ready), 64'd0);
    run_stream("DEADBEEF\015\n\n \n");
    check("stall_cycles", 64'(lowc), 64'd1);
    check("plan2_w0", obs_a[0], {32'h3000, 32'hdeadbeef});
    // reset asserted during the second line's write cycle
    apply_reset();
    begin
      string s = "11111111\n22222222\n";
      for (int i = 0; i < s.len(); i++) put(s[i]);
    end
    check("midwr_wr_en_before", 64'(ia.wr_en), 64'd1);
    #1 reset = 1'b0;
    #1;
    check("midwr_wr_en", 64'(ia.wr_en), 64'd0);
    check("midwr_ready", 64'(ia.in_ready), 64'd1);
    check("midwr_addr", 64'(ia.wr_addr), 64'h3000);
    check("midwr_data", 64'(ia.wr_data), 64'd0);
    check("midwr_flags", {wc_a, err_a, full_a, done_a}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    obs_a.delete();
    begin
      string s = "0000000a\n";
      for (int i = 0; i < s.len(); i++) put(s[i]);
    end
    repeat (3) @(negedge clk);
    check("midwr_nw", 64'(obs_a.size()), 64'd1);
    if (obs_a.size() > 0) check("midwr_w0", obs_a[0], {32'h3000, 32'h0000000a});
    check("midwr_cnt", 64'(wc_a), 64'd1);
    run_stream("abc\004");
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      ia.in_valid = 1'b1;
      ia.in_data = k[0] ? 8'h0a : 8'h31;
      check("done_ready", 64'(ia.in_ready), 64'd0);
    end
    @(negedge clk);
    ia.in_valid = 1'b0;
    check("done_nw", 64'(obs_a.size()), 64'd0);
    check("done_state", {wc_a, err_a, done_a}, {13'd0, 1'b1, 1'b1});
    for (int r = 0; r < 40; r++) run_stream(gen());
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
